// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Central stall/flush sequencer for the 5-stage RV32 pipeline. It resolves
//   three hazards and drives the advance/hold/flush controls of fetch, decode
//   and execute:
//   - EX branch/JAL mispredict
//   - ID-vs-EX load-use
//   - the multi-cycle multiplier
//   It also handles the global data-memory freeze and the multiplier
//   start/done handshake.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   freeze              data-memory wait, freezes the whole pipeline
//   ex_mispredict       EX redirects fetch to a corrected target
//   id_valid, id_is_mul ID holds a real instruction / a MUL-family op
//   id_rs1, id_rs2      ID source registers
//   id_use_rs1/rs2      ID actually reads that source
//   ex_is_load, ex_rd   EX holds a load writing ex_rd
//   fetch_adv           PC updates (predicted or corrected)
//   if_flush            IF/ID becomes a bubble
//   id_hold             IF/ID keeps its value
//   id_flush            bubble inserted into ID/EX
//   ex_hold             ID/EX and later registers keep their values
//   mul_start/mul_done  multiplier handshake pulses
//   stall_cycles        cycles with fetch_adv=0 outside reset (wraps)
module pipe_hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             freeze,
  input  logic             ex_mispredict,
  input  logic             id_valid,
  input  logic             id_is_mul,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd,
  output logic             fetch_adv,
  output logic             if_flush,
  output logic             id_hold,
  output logic             id_flush,
  output logic             ex_hold,
  output logic             mul_start,
  output logic             mul_done,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int LAT_W = $clog2(MUL_LAT + 1);

  typedef enum logic {RUN = 1'b0, MUL_BUSY = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [LAT_W-1:0] cnt, cnt_nxt;
  logic             load_use;

  // x0 is never a real dependency, so a load to x0 cannot cause a stall.
  assign load_use = ex_is_load && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; freeze holds both state and latency counter.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (!freeze) begin
      case (state)
        RUN: begin
          // A mispredict squashes the ID instruction, MUL included.
          if (!ex_mispredict && id_valid && id_is_mul) begin
            state_nxt = MUL_BUSY;
            cnt_nxt   = LAT_W'(MUL_LAT - 1);
          end
        end
        MUL_BUSY: begin
          if (cnt != '0) cnt_nxt = cnt - LAT_W'(1);
          else           state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // Output logic
  always_comb begin
    fetch_adv = 1'b0;
    if_flush  = 1'b0;
    id_hold   = 1'b0;
    id_flush  = 1'b0;
    ex_hold   = 1'b0;
    mul_start = 1'b0;
    mul_done  = 1'b0;
    if (reset) begin
      if_flush = 1'b1;
      id_flush = 1'b1;
    end else if (freeze) begin
      id_hold = 1'b1;
      ex_hold = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (ex_mispredict) begin
            fetch_adv = 1'b1;
            if_flush  = 1'b1;
            id_flush  = 1'b1;
          end else if (id_valid && id_is_mul) begin
            mul_start = 1'b1;
            id_hold   = 1'b1;
            id_flush  = 1'b1;
          end else if (load_use) begin
            id_hold  = 1'b1;
            id_flush = 1'b1;
          end else begin
            fetch_adv = 1'b1;
          end
        end
        MUL_BUSY: begin
          if (cnt != '0) begin
            id_hold  = 1'b1;
            id_flush = 1'b1;
          end else begin
            mul_done  = 1'b1;
            fetch_adv = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Stall counter; freeze cycles count as stalls too.
  always_ff @(posedge clk) begin
    if (reset)           stall_cycles <= '0;
    else if (!fetch_adv) stall_cycles <= stall_cycles + CNT_W'(1);
  end

  // Handshake and control-consistency checks. mul_start is only legal from
  // RUN and mul_done only from MUL_BUSY, so every start gets exactly one done
  // unless reset drops the FSM back to RUN.
  always @(posedge clk) begin
    if (!reset) begin
      assert (!(if_flush && id_hold));
      assert (!(mul_start && mul_done));
      assert (!mul_start || state == RUN);
      assert (!mul_done || state == MUL_BUSY);
      assert (freeze || state != MUL_BUSY || !ex_mispredict);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with MUL_LAT=4. Inputs change 1ns after
// the rising edge, outputs are sampled 2ns after it.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        freeze;
  logic        ex_mispredict;
  logic        id_valid;
  logic        id_is_mul;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic        id_use_rs1;
  logic        id_use_rs2;
  logic        ex_is_load;
  logic [4:0]  ex_rd;
  logic        fetch_adv;
  logic        if_flush;
  logic        id_hold;
  logic        id_flush;
  logic        ex_hold;
  logic        mul_start;
  logic        mul_done;
  logic [31:0] stall_cycles;

  // {fetch_adv, if_flush, id_hold, id_flush, ex_hold, mul_start, mul_done}
  logic [6:0]  outs;
  assign outs = {fetch_adv, if_flush, id_hold, id_flush, ex_hold, mul_start, mul_done};

  localparam logic [6:0] O_RST    = 7'b0101000;
  localparam logic [6:0] O_RUN    = 7'b1000000;
  localparam logic [6:0] O_STALL  = 7'b0011000;
  localparam logic [6:0] O_START  = 7'b0011010;
  localparam logic [6:0] O_DONE   = 7'b1000001;
  localparam logic [6:0] O_MISP   = 7'b1101000;
  localparam logic [6:0] O_FREEZE = 7'b0010100;

  int n_chk  = 0;
  int n_pass = 0;

  pipe_hazard_ctrl #(.MUL_LAT(4), .CNT_W(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .freeze       (freeze),
    .ex_mispredict(ex_mispredict),
    .id_valid     (id_valid),
    .id_is_mul    (id_is_mul),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .ex_is_load   (ex_is_load),
    .ex_rd        (ex_rd),
    .fetch_adv    (fetch_adv),
    .if_flush     (if_flush),
    .id_hold      (id_hold),
    .id_flush     (id_flush),
    .ex_hold      (ex_hold),
    .mul_start    (mul_start),
    .mul_done     (mul_done),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    if (obs === exp_v) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after an input change.
  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    freeze = 0; ex_mispredict = 0; id_valid = 0; id_is_mul = 0;
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_is_load = 0; ex_rd = 0;
  endtask

  initial begin
    reset = 1;
    idle_inputs();

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      cyc(); settle();
      chk($sformatf("reset_outs%0d", i), outs, O_RST);
    end
    chk("reset_stall", stall_cycles, 0);

    cyc(); reset = 0; settle();
    chk("run_outs", outs, O_RUN);
    cyc(); settle();
    chk("run_stall", stall_cycles, 0);

    // MUL in ID: start at t, stalled t..t+3, done at t+4
    id_valid = 1; id_is_mul = 1; settle();
    chk("mul_start", outs, O_START);
    for (int i = 1; i <= 3; i++) begin
      cyc(); settle();
      chk($sformatf("mul_busy%0d", i), outs, O_STALL);
    end
    cyc(); settle();
    chk("mul_done", outs, O_DONE);
    chk("mul_stall_cnt", stall_cycles, 4);
    cyc(); idle_inputs(); settle();
    chk("mul_after", outs, O_RUN);

    // Load x5 in EX, ID reads rs2=x5: one-cycle stall
    ex_is_load = 1; ex_rd = 5; id_valid = 1;
    id_rs1 = 3; id_use_rs1 = 1; id_rs2 = 5; id_use_rs2 = 1; settle();
    chk("lu_rs2_stall", outs, O_STALL);
    cyc(); ex_is_load = 0; ex_rd = 0; settle();
    chk("lu_clear", outs, O_RUN);
    chk("lu_stall_cnt", stall_cycles, 5);

    // Same operands with ex_rd=x0: no stall
    ex_is_load = 1; ex_rd = 0; id_rs2 = 0; settle();
    chk("lu_x0", outs, O_RUN);
    // rs1 matches but is not read: no stall
    ex_rd = 7; id_rs1 = 7; id_use_rs1 = 0; id_rs2 = 2; settle();
    chk("lu_rs1_unused", outs, O_RUN);
    // rs1 matches and is read: stall
    id_use_rs1 = 1; settle();
    chk("lu_rs1_stall", outs, O_STALL);
    cyc(); idle_inputs(); settle();
    chk("lu_stall_cnt2", stall_cycles, 6);

    // Mispredict beats MUL and load-use together
    ex_mispredict = 1; id_valid = 1; id_is_mul = 1;
    ex_is_load = 1; ex_rd = 9; id_rs1 = 9; id_use_rs1 = 1; settle();
    chk("misp_outs", outs, O_MISP);
    cyc(); idle_inputs(); settle();
    chk("misp_stays_run", outs, O_RUN);
    chk("misp_stall_cnt", stall_cycles, 6);

    // MUL with 3 freeze cycles while cnt=2: done moves from t+4 to t+7
    id_valid = 1; id_is_mul = 1; settle();
    chk("fz_mul_start", outs, O_START);
    cyc(); idle_inputs(); settle();
    chk("fz_busy_c3", outs, O_STALL);
    cyc(); freeze = 1; settle();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("fz_frozen%0d", i), outs, O_FREEZE);
      cyc(); settle();
    end
    freeze = 0; settle();
    chk("fz_busy_c2", outs, O_STALL);
    cyc(); settle();
    chk("fz_busy_c1", outs, O_STALL);
    cyc(); settle();
    chk("fz_mul_done", outs, O_DONE);
    chk("fz_stall_cnt", stall_cycles, 13);

    // Freeze in RUN masks a mispredict until it drops
    cyc(); freeze = 1; ex_mispredict = 1; settle();
    chk("fz_misp_masked", outs, O_FREEZE);
    cyc(); freeze = 0; settle();
    chk("fz_misp_acted", outs, O_MISP);
    chk("fz_misp_stall_cnt", stall_cycles, 14);
    cyc(); idle_inputs(); settle();

    // Reset at cnt=1 in MUL_BUSY aborts the multiply
    id_valid = 1; id_is_mul = 1; settle();
    chk("rst_mul_start", outs, O_START);
    cyc(); idle_inputs(); cyc(); cyc(); settle();
    chk("rst_busy_c1", outs, O_STALL);
    reset = 1; settle();
    chk("rst_in_busy", outs, O_RST);
    cyc(); reset = 0; settle();
    chk("rst_no_done", outs, O_RUN);
    chk("rst_stall_cnt", stall_cycles, 0);
    cyc(); settle();
    chk("rst_still_run", outs, O_RUN);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
